// File: rtl/fpmul_pipe.sv
// fpmul_pipe: three-stage pipelined floating-point multiplier.
//   Operands are {sign, exp[EXP_W], man[MAN_W]} with a hidden leading one.
//   exp==0 means zero (any mantissa). There are no inf/NaN encodings.
//   S1 multiplies, S2 normalises and rounds, S3 classifies and registers the result.
//   Each stage advances when it is empty or when the stage after it advances.
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   in_valid/in_ready          operand handshake
//   in_a, in_b                 operands (W bits)
//   in_rnd                     0 = round-nearest-even, 1 = truncate
//   in_tag                     sideband tag, passed through unchanged
//   out_valid/out_ready        result handshake
//   out_p, out_tag             product and its tag
//   out_ovf, out_unf           saturated / flushed-to-zero flags (valid with out_valid)
module fpmul_pipe #(
  parameter  int EXP_W = 4,
  parameter  int MAN_W = 3,
  parameter  int TAG_W = 4,
  localparam int W     = EXP_W + MAN_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic             in_rnd,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_p,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_ovf,
  output logic             out_unf
);

  localparam int STAGES = 3;
  localparam int EW     = EXP_W + 2;     // signed working exponent
  localparam int PW     = 2 * MAN_W + 2; // full significand product
  localparam int BIAS   = 2 ** (EXP_W - 1) - 1;

  localparam logic [EW-1:0]        BIAS_E = EW'(BIAS);
  localparam logic signed [EW-1:0] MAX_E  = EW'(2 ** EXP_W - 1);
  localparam logic signed [EW-1:0] MIN_E  = EW'(1);

  typedef struct packed {
    logic             sign;
    logic             zero;
    logic [EW-1:0]    exp;
    logic [PW-1:0]    prod;
    logic             rnd;
    logic [TAG_W-1:0] tag;
  } s1_t;

  typedef struct packed {
    logic             sign;
    logic             zero;
    logic [EW-1:0]    exp;
    logic [MAN_W-1:0] man;
    logic [TAG_W-1:0] tag;
  } s2_t;

  logic [STAGES:1] vld_pipe;
  logic            adv1, adv2, adv3;
  s1_t             s1_d, s1_q;
  s2_t             s2_d, s2_q;

  // ---------------- flow control ----------------
  assign adv3      = !vld_pipe[3] || out_ready;
  assign adv2      = !vld_pipe[2] || adv3;
  assign adv1      = !vld_pipe[1] || adv2;
  assign in_ready  = !rst && adv1;
  assign out_valid = vld_pipe[3];

  // ---------------- S1: multiply ----------------
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] ma, mb;

  always_comb begin
    ea        = in_a[W-2:MAN_W];
    eb        = in_b[W-2:MAN_W];
    ma        = in_a[MAN_W-1:0];
    mb        = in_b[MAN_W-1:0];
    s1_d.sign = in_a[W-1] ^ in_b[W-1];
    s1_d.zero = (ea == '0) || (eb == '0);
    // Two's complement in EW bits; range always fits for EXP_W >= 3.
    s1_d.exp  = {2'b00, ea} + {2'b00, eb} - BIAS_E;
    s1_d.prod = PW'({1'b1, ma}) * PW'({1'b1, mb});
    s1_d.rnd  = in_rnd;
    s1_d.tag  = in_tag;
  end

  // ---------------- S2: normalise and round ----------------
  logic [2*MAN_W:0]  frac;   // bits below the leading one
  logic [EW-1:0]     nexp;
  logic [MAN_W-1:0]  man_t;
  logic              guard, sticky, inc;
  logic [MAN_W:0]    man_sum;

  always_comb begin
    // Product lies in [1,4). When the MSB is set the bit shifted out on the
    // right lands in the lowest frac position so it still feeds sticky.
    if (s1_q.prod[PW-1]) begin
      frac = s1_q.prod[PW-2:0];
      nexp = s1_q.exp + EW'(1);
    end else begin
      frac = {s1_q.prod[PW-3:0], 1'b0};
      nexp = s1_q.exp;
    end
    man_t   = frac[2*MAN_W:MAN_W+1];
    guard   = frac[MAN_W];
    sticky  = |frac[MAN_W-1:0];
    inc     = !s1_q.rnd && guard && (sticky || man_t[0]);
    man_sum = {1'b0, man_t} + {{MAN_W{1'b0}}, inc};

    s2_d.sign = s1_q.sign;
    s2_d.zero = s1_q.zero;
    s2_d.tag  = s1_q.tag;
    s2_d.man  = man_sum[MAN_W-1:0];  // wraps to 0 on carry out
    s2_d.exp  = man_sum[MAN_W] ? nexp + EW'(1) : nexp;
  end

  // ---------------- S3: classify ----------------
  logic [W-1:0] p_d;
  logic         ovf_d, unf_d;

  always_comb begin
    p_d   = {s2_q.sign, {(W-1){1'b0}}};
    ovf_d = 1'b0;
    unf_d = 1'b0;
    if (s2_q.zero) begin
      p_d = {s2_q.sign, {(W-1){1'b0}}};
    end else if ($signed(s2_q.exp) > MAX_E) begin
      p_d   = {s2_q.sign, {(W-1){1'b1}}};
      ovf_d = 1'b1;
    end else if ($signed(s2_q.exp) < MIN_E) begin
      unf_d = 1'b1;
    end else begin
      p_d = {s2_q.sign, s2_q.exp[EXP_W-1:0], s2_q.man};
    end
  end

  // ---------------- pipeline registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
      out_p    <= '0;
      out_tag  <= '0;
      out_ovf  <= 1'b0;
      out_unf  <= 1'b0;
    end else begin
      if (adv1) begin
        vld_pipe[1] <= in_valid;
        if (in_valid) s1_q <= s1_d;
      end
      if (adv2) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) s2_q <= s2_d;
      end
      if (adv3) begin
        vld_pipe[3] <= vld_pipe[2];
        if (vld_pipe[2]) begin
          out_p   <= p_d;
          out_tag <= s2_q.tag;
          out_ovf <= ovf_d;
          out_unf <= unf_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_fpmul_pipe.sv
// tb_fpmul_pipe: directed self-checking bench for fpmul_pipe (EXP_W=4, MAN_W=3, TAG_W=4).
module tb_fpmul_pipe;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       in_rnd;
  logic [3:0] in_tag;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_p;
  logic [3:0] out_tag;
  logic       out_ovf;
  logic       out_unf;

  int errors = 0;
  int checks = 0;

  fpmul_pipe #(.EXP_W(4), .MAN_W(3), .TAG_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_rnd(in_rnd), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_p(out_p), .out_tag(out_tag), .out_ovf(out_ovf), .out_unf(out_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_p !== 8'h00 || out_tag !== 4'h0 ||
        out_ovf !== 1'b0 || out_unf !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b p=%h tag=%h ovf=%b unf=%b, want all 0",
               out_valid, out_p, out_tag, out_ovf, out_unf);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 0", in_ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL release_in_ready: got %b want 1", in_ready);
    end
  endtask

  // Single isolated operation: checks latency, product, flags and tag.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic rnd,
                       input logic [3:0] tag, input logic [7:0] ep,
                       input logic eo, input logic eu, input string nm);
    int n;
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_b = b; in_rnd = rnd; in_tag = tag;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_in_ready: got %b want 1", nm, in_ready);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    n = 0;
    while (n < 10) begin
      @(negedge clk);
      n++;
      if (out_valid === 1'b1) break;
    end
    checks++;
    if (n != 3 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_latency: got %0d cycles (valid=%b) want 3", nm, n, out_valid);
    end
    checks++;
    if (out_p !== ep) begin
      errors++;
      $display("FAIL %s_p: got %h want %h", nm, out_p, ep);
    end
    checks++;
    if (out_ovf !== eo || out_unf !== eu) begin
      errors++;
      $display("FAIL %s_flags: got ovf=%b unf=%b want ovf=%b unf=%b", nm, out_ovf, out_unf, eo, eu);
    end
    checks++;
    if (out_tag !== tag) begin
      errors++;
      $display("FAIL %s_tag: got %h want %h", nm, out_tag, tag);
    end
  endtask

  task automatic test_basic();
    do_op(8'h3C, 8'h3C, 1'b0, 4'h5, 8'h41, 1'b0, 1'b0, "mul_1p5_sq");
  endtask

  task automatic test_rounding();
    do_op(8'h39, 8'h3C, 1'b0, 4'h1, 8'h3E, 1'b0, 1'b0, "tie_rne");
    do_op(8'h39, 8'h3C, 1'b1, 4'h2, 8'h3D, 1'b0, 1'b0, "tie_trunc");
    do_op(8'h3F, 8'h39, 1'b0, 4'h3, 8'h40, 1'b0, 1'b0, "norm_carry");
  endtask

  task automatic test_saturation();
    do_op(8'h7F, 8'h7F, 1'b0, 4'h4, 8'h7F, 1'b1, 1'b0, "sat_pos");
    do_op(8'hFF, 8'h7F, 1'b0, 4'h6, 8'hFF, 1'b1, 1'b0, "sat_neg");
  endtask

  task automatic test_underflow_zero();
    do_op(8'h08, 8'h08, 1'b0, 4'h7, 8'h00, 1'b0, 1'b1, "unf_pos");
    do_op(8'h88, 8'h08, 1'b0, 4'h8, 8'h80, 1'b0, 1'b1, "unf_neg");
    do_op(8'h00, 8'h7F, 1'b0, 4'h9, 8'h00, 1'b0, 1'b0, "zero_pos");
    do_op(8'h80, 8'h38, 1'b0, 4'hA, 8'h80, 1'b0, 1'b0, "zero_neg");
  endtask

  task automatic test_backpressure();
    logic [7:0] va [5];
    logic [7:0] vb [5];
    logic [7:0] vp [5];
    int acc;
    int got;
    int idx;
    va[0] = 8'h3C; vb[0] = 8'h3C; vp[0] = 8'h41;
    va[1] = 8'h39; vb[1] = 8'h3C; vp[1] = 8'h3E;
    va[2] = 8'h3F; vb[2] = 8'h39; vp[2] = 8'h40;
    va[3] = 8'h7F; vb[3] = 8'h7F; vp[3] = 8'h7F;
    va[4] = 8'h08; vb[4] = 8'h08; vp[4] = 8'h00;
    acc = 0;
    got = 0;
    @(negedge clk);
    out_ready = 1'b0;
    in_rnd = 1'b0;
    for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
      if (cyc != 0) @(negedge clk);
      if (cyc == 5) begin
        checks++;
        if (out_valid !== 1'b1 || out_p !== 8'h41 || out_tag !== 4'h1) begin
          errors++;
          $display("FAIL bp_hold: got v=%b p=%h tag=%h want v=1 p=41 tag=1", out_valid, out_p, out_tag);
        end
      end
      if (cyc == 6) begin
        checks++;
        if (acc != 3 || in_ready !== 1'b0) begin
          errors++;
          $display("FAIL bp_accepts: got acc=%0d in_ready=%b want acc=3 in_ready=0", acc, in_ready);
        end
        out_ready = 1'b1;
      end
      idx = (acc < 5) ? acc : 0;
      in_valid = (acc < 5);
      in_a = va[idx]; in_b = vb[idx]; in_tag = 4'(idx + 1);
      #1;
      if (out_ready) begin
        checks++;
        if (out_valid !== 1'b1) begin
          errors++;
          $display("FAIL bp_gap: got out_valid=%b at result %0d want 1", out_valid, got);
        end else begin
          checks++;
          if (out_p !== vp[got] || out_tag !== 4'(got + 1)) begin
            errors++;
            $display("FAIL bp_order: result %0d got p=%h tag=%h want p=%h tag=%h",
                     got, out_p, out_tag, vp[got], 4'(got + 1));
          end
          got++;
        end
      end
      if (in_valid && in_ready) acc++;
    end
    checks++;
    if (got != 5) begin
      errors++;
      $display("FAIL bp_drain_count: got %0d want 5", got);
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_dup: got out_valid=%b after drain want 0", out_valid);
    end
  endtask

  task automatic test_reset_mid();
    logic stale;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = 8'h3C; in_b = 8'h3C; in_rnd = 1'b0; in_tag = 4'h6;
    @(posedge clk);
    #1 in_a = 8'h39; in_tag = 4'h7;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_p !== 8'h41 || out_tag !== 4'h6) begin
      errors++;
      $display("FAIL rst_pre: got v=%b p=%h tag=%h want v=1 p=41 tag=6", out_valid, out_p, out_tag);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_p !== 8'h00 || out_tag !== 4'h0 ||
        out_ovf !== 1'b0 || out_unf !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_async: got v=%b p=%h tag=%h ovf=%b unf=%b rdy=%b want all 0",
               out_valid, out_p, out_tag, out_ovf, out_unf, in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    stale = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) stale = 1'b1;
    end
    checks++;
    if (stale) begin
      errors++;
      $display("FAIL rst_stale: got out_valid=1 after release want 0");
    end
    do_op(8'h3C, 8'h3C, 1'b0, 4'hB, 8'h41, 1'b0, 1'b0, "post_rst");
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    in_rnd = 1'b0;
    in_tag = '0;
    out_ready = 1'b1;
    test_reset();
    test_basic();
    test_rounding();
    test_saturation();
    test_underflow_zero();
    test_backpressure();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
